// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID pipeline register, 32-entry register file with
// write-through bypass, and combinational main/ALU/immediate decode.
module decode_stage #(
  parameter int                    INST_Width = 32,
  parameter int                    Reg_Count  = 32,
  parameter logic [INST_Width-1:0] NOP_Instr  = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_Stall_D,
  input  logic                          i_Flush_D,
  input  logic [INST_Width-1:0]         i_Instr_F,
  input  logic [INST_Width-1:0]         i_PC_F,
  input  logic [INST_Width-1:0]         i_PCPluse4_F,
  input  logic                          i_RegWrite_W,
  input  logic [$clog2(Reg_Count)-1:0]  i_Rd_W,
  input  logic [INST_Width-1:0]         i_Result_W,
  output logic                          o_Valid_D,
  output logic [INST_Width-1:0]         o_PC_D,
  output logic [INST_Width-1:0]         o_PCPluse4_D,
  output logic [INST_Width-1:0]         o_RD1_D,
  output logic [INST_Width-1:0]         o_RD2_D,
  output logic [INST_Width-1:0]         o_ImmExt_D,
  output logic [$clog2(Reg_Count)-1:0]  o_Rs1_D,
  output logic [$clog2(Reg_Count)-1:0]  o_Rs2_D,
  output logic [$clog2(Reg_Count)-1:0]  o_Rd_D,
  output logic                          o_RegWrite_D,
  output logic [1:0]                    o_ResultSrc_D,
  output logic                          o_MemWrite_D,
  output logic                          o_Jump_D,
  output logic                          o_Branch_D,
  output logic                          o_ALUSrc_D,
  output logic [2:0]                    o_ALUControl_D,
  output logic                          o_Illegal_D
);

  localparam int IDX_W = $clog2(Reg_Count);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ---------------- IF/ID pipeline register ----------------
  logic [INST_Width-1:0] instr_q, instr_d;
  logic [INST_Width-1:0] pc_q, pc_d;
  logic [INST_Width-1:0] pcp4_q, pcp4_d;
  logic                  valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (i_Flush_D) begin
      instr_d = NOP_Instr;
      pc_d    = '0;
      pcp4_d  = '0;
      valid_d = 1'b0;
    end else if (!i_Stall_D) begin
      instr_d = i_Instr_F;
      pc_d    = i_PC_F;
      pcp4_d  = i_PCPluse4_F;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_Instr;
      pc_q    <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  // ---------------- Register file ----------------
  logic [INST_Width-1:0] rf_q [Reg_Count];
  logic                  wr_en;
  logic [IDX_W-1:0]      rs_idx  [2];
  logic [INST_Width-1:0] rd_data [2];

  assign wr_en     = i_RegWrite_W && (i_Rd_W != '0);
  assign rs_idx[0] = instr_q[19:15];
  assign rs_idx[1] = instr_q[24:20];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < Reg_Count; k++) rf_q[k] <= '0;
    end else if (wr_en) begin
      rf_q[i_Rd_W] <= i_Result_W;
    end
  end

  // Writeback data bypasses the array so a same-cycle producer is visible.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_data[gi] = (rs_idx[gi] == '0)                  ? '0 :
                           (wr_en && (i_Rd_W == rs_idx[gi]))  ? i_Result_W :
                                                                rf_q[rs_idx[gi]];
    end
  endgenerate

  assign o_RD1_D      = rd_data[0];
  assign o_RD2_D      = rd_data[1];
  assign o_Rs1_D      = instr_q[19:15];
  assign o_Rs2_D      = instr_q[24:20];
  assign o_Rd_D       = instr_q[11:7];
  assign o_Valid_D    = valid_q;
  assign o_PC_D       = pc_q;
  assign o_PCPluse4_D = pcp4_q;

  // ---------------- Decode ----------------
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [INST_Width-1:0] imm_i, imm_s, imm_b, imm_j;
  logic                  alu_ok;
  logic [2:0]            alu_fn;
  logic                  legal;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_j  = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  // funct7[5] selects sub only for register-register ops; addi never subtracts.
  always_comb begin
    alu_ok = 1'b1;
    alu_fn = 3'b000;
    case (funct3)
      3'b000:  alu_fn = ((opcode == OP_R) && instr_q[30]) ? 3'b001 : 3'b000;
      3'b010:  alu_fn = 3'b101;
      3'b110:  alu_fn = 3'b011;
      3'b111:  alu_fn = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    legal          = 1'b0;
    o_RegWrite_D   = 1'b0;
    o_ResultSrc_D  = 2'b00;
    o_MemWrite_D   = 1'b0;
    o_Jump_D       = 1'b0;
    o_Branch_D     = 1'b0;
    o_ALUSrc_D     = 1'b0;
    o_ALUControl_D = 3'b000;
    o_ImmExt_D     = '0;
    case (opcode)
      OP_LW: if (funct3 == 3'b010) begin
        legal = 1'b1; o_RegWrite_D = 1'b1; o_ALUSrc_D = 1'b1;
        o_ResultSrc_D = 2'b01; o_ImmExt_D = imm_i;
      end
      OP_SW: if (funct3 == 3'b010) begin
        legal = 1'b1; o_MemWrite_D = 1'b1; o_ALUSrc_D = 1'b1; o_ImmExt_D = imm_s;
      end
      OP_R: if (alu_ok) begin
        legal = 1'b1; o_RegWrite_D = 1'b1; o_ALUControl_D = alu_fn;
      end
      OP_I: if (alu_ok) begin
        legal = 1'b1; o_RegWrite_D = 1'b1; o_ALUSrc_D = 1'b1;
        o_ALUControl_D = alu_fn; o_ImmExt_D = imm_i;
      end
      OP_BEQ: if (funct3 == 3'b000) begin
        legal = 1'b1; o_Branch_D = 1'b1; o_ALUControl_D = 3'b001; o_ImmExt_D = imm_b;
      end
      OP_JAL: begin
        legal = 1'b1; o_RegWrite_D = 1'b1; o_Jump_D = 1'b1;
        o_ResultSrc_D = 2'b10; o_ImmExt_D = imm_j;
      end
      default: legal = 1'b0;
    endcase
  end

  assign o_Illegal_D = valid_q && !legal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: reset, decode, bypass, stall/flush, illegal.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Stall_D, i_Flush_D;
  logic [31:0] i_Instr_F, i_PC_F, i_PCPluse4_F;
  logic        i_RegWrite_W;
  logic [4:0]  i_Rd_W;
  logic [31:0] i_Result_W;
  logic        o_Valid_D;
  logic [31:0] o_PC_D, o_PCPluse4_D, o_RD1_D, o_RD2_D, o_ImmExt_D;
  logic [4:0]  o_Rs1_D, o_Rs2_D, o_Rd_D;
  logic        o_RegWrite_D;
  logic [1:0]  o_ResultSrc_D;
  logic        o_MemWrite_D, o_Jump_D, o_Branch_D, o_ALUSrc_D;
  logic [2:0]  o_ALUControl_D;
  logic        o_Illegal_D;

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .i_Stall_D(i_Stall_D), .i_Flush_D(i_Flush_D),
    .i_Instr_F(i_Instr_F), .i_PC_F(i_PC_F), .i_PCPluse4_F(i_PCPluse4_F),
    .i_RegWrite_W(i_RegWrite_W), .i_Rd_W(i_Rd_W), .i_Result_W(i_Result_W),
    .o_Valid_D(o_Valid_D), .o_PC_D(o_PC_D), .o_PCPluse4_D(o_PCPluse4_D),
    .o_RD1_D(o_RD1_D), .o_RD2_D(o_RD2_D), .o_ImmExt_D(o_ImmExt_D),
    .o_Rs1_D(o_Rs1_D), .o_Rs2_D(o_Rs2_D), .o_Rd_D(o_Rd_D),
    .o_RegWrite_D(o_RegWrite_D), .o_ResultSrc_D(o_ResultSrc_D),
    .o_MemWrite_D(o_MemWrite_D), .o_Jump_D(o_Jump_D), .o_Branch_D(o_Branch_D),
    .o_ALUSrc_D(o_ALUSrc_D), .o_ALUControl_D(o_ALUControl_D), .o_Illegal_D(o_Illegal_D)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    i_Instr_F = instr; i_PC_F = pc; i_PCPluse4_F = pc + 32'd4;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (o_Valid_D !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", o_Valid_D); end
    total++; if (o_PC_D !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", o_PC_D); end
    total++; if (o_RegWrite_D !== 1'b1) begin bad++; $display("FAIL rst_regwrite got=%b exp=1", o_RegWrite_D); end
    total++; if (o_Rd_D !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d exp=0", o_Rd_D); end
    total++; if (o_ALUSrc_D !== 1'b1) begin bad++; $display("FAIL rst_alusrc got=%b exp=1", o_ALUSrc_D); end
    total++; if (o_ALUControl_D !== 3'b000) begin bad++; $display("FAIL rst_aluctl got=%b exp=000", o_ALUControl_D); end
    total++; if (o_ImmExt_D !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h exp=0", o_ImmExt_D); end
    total++; if (o_Illegal_D !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%b exp=0", o_Illegal_D); end
    // Sweep every register index through both read ports: add x0,xi,xi.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      load({7'b0, r, r, 3'b000, 5'd0, 7'b0110011}, 32'h0);
      total++; if (o_RD1_D !== 32'h0 || o_RD2_D !== 32'h0) begin
        bad++; $display("FAIL rst_rf x%0d got=%h/%h exp=0", i, o_RD1_D, o_RD2_D);
      end
    end
    $display("reset: sweep done");
  endtask

  task automatic test_addi();
    load(32'h00500293, 32'h10);
    total++; if (o_Rd_D !== 5'd5) begin bad++; $display("FAIL addi_rd got=%0d exp=5", o_Rd_D); end
    total++; if (o_ImmExt_D !== 32'd5) begin bad++; $display("FAIL addi_imm got=%h exp=5", o_ImmExt_D); end
    total++; if (o_ALUSrc_D !== 1'b1 || o_RegWrite_D !== 1'b1) begin bad++; $display("FAIL addi_ctl got=%b%b exp=11", o_ALUSrc_D, o_RegWrite_D); end
    total++; if (o_PC_D !== 32'h10 || o_PCPluse4_D !== 32'h14) begin bad++; $display("FAIL addi_pc got=%h/%h exp=10/14", o_PC_D, o_PCPluse4_D); end
    total++; if (o_Valid_D !== 1'b1 || o_Illegal_D !== 1'b0) begin bad++; $display("FAIL addi_valid got=%b%b exp=10", o_Valid_D, o_Illegal_D); end
    $display("addi: rd=%0d imm=%h pc=%h", o_Rd_D, o_ImmExt_D, o_PC_D);
  endtask

  task automatic test_bypass();
    load(32'h00528333, 32'h20); // add x6,x5,x5
    i_RegWrite_W = 1'b1; i_Rd_W = 5'd5; i_Result_W = 32'hDEADBEEF;
    #1;
    total++; if (o_RD1_D !== 32'hDEADBEEF || o_RD2_D !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass got=%h/%h exp=deadbeef", o_RD1_D, o_RD2_D); end
    total++; if (o_ALUSrc_D !== 1'b0 || o_ALUControl_D !== 3'b000 || o_Rs1_D !== 5'd5 || o_Rs2_D !== 5'd5) begin
      bad++; $display("FAIL add_ctl got=%b %b %0d %0d exp=0 000 5 5", o_ALUSrc_D, o_ALUControl_D, o_Rs1_D, o_Rs2_D);
    end
    tick();
    i_RegWrite_W = 1'b0;
    #1;
    total++; if (o_RD1_D !== 32'hDEADBEEF) begin bad++; $display("FAIL stored_x5 got=%h exp=deadbeef", o_RD1_D); end
    load(32'h00000333, 32'h24); // add x6,x0,x0
    i_RegWrite_W = 1'b1; i_Rd_W = 5'd0; i_Result_W = 32'h7;
    #1;
    total++; if (o_RD1_D !== 32'h0) begin bad++; $display("FAIL x0_bypass got=%h exp=0", o_RD1_D); end
    tick();
    i_RegWrite_W = 1'b0;
    #1;
    total++; if (o_RD1_D !== 32'h0) begin bad++; $display("FAIL x0_write got=%h exp=0", o_RD1_D); end
    load(32'h40528333, 32'h28); // sub x6,x5,x5
    total++; if (o_ALUControl_D !== 3'b001) begin bad++; $display("FAIL sub_ctl got=%b exp=001", o_ALUControl_D); end
    $display("bypass: x5=%h", o_RD1_D);
  endtask

  task automatic test_stall_flush();
    load(32'h00500293, 32'h40);
    i_Stall_D = 1'b1;
    for (int c = 0; c < 3; c++) begin
      load(32'h00528333 + 32'(c), 32'h50 + 32'(c));
      total++; if (o_PC_D !== 32'h40 || o_Rd_D !== 5'd5 || o_ImmExt_D !== 32'd5 || o_Valid_D !== 1'b1) begin
        bad++; $display("FAIL stall_hold c=%0d got pc=%h rd=%0d imm=%h v=%b exp pc=40 rd=5 imm=5 v=1", c, o_PC_D, o_Rd_D, o_ImmExt_D, o_Valid_D);
      end
    end
    i_Flush_D = 1'b1;
    tick();
    i_Flush_D = 1'b0; i_Stall_D = 1'b0;
    total++; if (o_Valid_D !== 1'b0 || o_PC_D !== 32'h0 || o_Rd_D !== 5'd0 || o_ImmExt_D !== 32'h0 || o_RegWrite_D !== 1'b1) begin
      bad++; $display("FAIL stall_flush got v=%b pc=%h rd=%0d imm=%h rw=%b exp v=0 pc=0 rd=0 imm=0 rw=1", o_Valid_D, o_PC_D, o_Rd_D, o_ImmExt_D, o_RegWrite_D);
    end
    $display("stall_flush: valid=%b pc=%h", o_Valid_D, o_PC_D);
  endtask

  task automatic test_branch_jump_mem();
    load(32'hFE000EE3, 32'h60); // beq x0,x0,-4
    total++; if (o_ImmExt_D !== 32'hFFFFFFFC) begin bad++; $display("FAIL beq_imm got=%h exp=fffffffc", o_ImmExt_D); end
    total++; if (o_Branch_D !== 1'b1 || o_ALUControl_D !== 3'b001 || o_RegWrite_D !== 1'b0) begin
      bad++; $display("FAIL beq_ctl got br=%b alu=%b rw=%b exp 1 001 0", o_Branch_D, o_ALUControl_D, o_RegWrite_D);
    end
    load(32'h008000EF, 32'h64); // jal x1,8
    total++; if (o_ImmExt_D !== 32'd8 || o_ResultSrc_D !== 2'b10) begin bad++; $display("FAIL jal got imm=%h rs=%b exp 8 10", o_ImmExt_D, o_ResultSrc_D); end
    total++; if (o_Jump_D !== 1'b1 || o_RegWrite_D !== 1'b1 || o_Rd_D !== 5'd1) begin
      bad++; $display("FAIL jal_ctl got j=%b rw=%b rd=%0d exp 1 1 1", o_Jump_D, o_RegWrite_D, o_Rd_D);
    end
    load(32'hFF812383, 32'h68); // lw x7,-8(x2)
    total++; if (o_ImmExt_D !== 32'hFFFFFFF8 || o_ResultSrc_D !== 2'b01 || o_ALUSrc_D !== 1'b1 || o_RegWrite_D !== 1'b1) begin
      bad++; $display("FAIL lw got imm=%h rs=%b as=%b rw=%b exp fffffff8 01 1 1", o_ImmExt_D, o_ResultSrc_D, o_ALUSrc_D, o_RegWrite_D);
    end
    load(32'h00712623, 32'h6C); // sw x7,12(x2)
    total++; if (o_ImmExt_D !== 32'd12 || o_MemWrite_D !== 1'b1 || o_ALUSrc_D !== 1'b1 || o_RegWrite_D !== 1'b0) begin
      bad++; $display("FAIL sw got imm=%h mw=%b as=%b rw=%b exp c 1 1 0", o_ImmExt_D, o_MemWrite_D, o_ALUSrc_D, o_RegWrite_D);
    end
    load(32'h0020A1B3, 32'h70); // slt x3,x1,x2
    total++; if (o_ALUControl_D !== 3'b101) begin bad++; $display("FAIL slt got=%b exp=101", o_ALUControl_D); end
    $display("branch_jump_mem: done");
  endtask

  task automatic test_illegal();
    load(32'hFFFFFFFF, 32'h80);
    total++; if (o_Illegal_D !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b exp=1", o_Illegal_D); end
    total++; if ({o_RegWrite_D, o_ResultSrc_D, o_MemWrite_D, o_Jump_D, o_Branch_D, o_ALUSrc_D, o_ALUControl_D} !== 10'b0 || o_ImmExt_D !== 32'h0) begin
      bad++; $display("FAIL ill_ctl got rw=%b rs=%b mw=%b j=%b br=%b as=%b alu=%b imm=%h exp all 0", o_RegWrite_D, o_ResultSrc_D, o_MemWrite_D, o_Jump_D, o_Branch_D, o_ALUSrc_D, o_ALUControl_D, o_ImmExt_D);
    end
    i_Flush_D = 1'b1;
    tick();
    i_Flush_D = 1'b0;
    total++; if (o_Illegal_D !== 1'b0 || o_Valid_D !== 1'b0) begin bad++; $display("FAIL ill_flush got ill=%b v=%b exp 0 0", o_Illegal_D, o_Valid_D); end
    load(32'h00109093, 32'h84); // slli: unsupported funct3
    total++; if (o_Illegal_D !== 1'b1 || o_RegWrite_D !== 1'b0) begin bad++; $display("FAIL ill_funct3 got ill=%b rw=%b exp 1 0", o_Illegal_D, o_RegWrite_D); end
    $display("illegal: done");
  endtask

  task automatic test_reset_midop();
    i_RegWrite_W = 1'b1; i_Rd_W = 5'd5; i_Result_W = 32'h12345678;
    load(32'h00528333, 32'h90);
    i_RegWrite_W = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (o_Valid_D !== 1'b0 || o_PC_D !== 32'h0) begin bad++; $display("FAIL midrst_ifid got v=%b pc=%h exp 0 0", o_Valid_D, o_PC_D); end
    load(32'h00528333, 32'h94);
    total++; if (o_RD1_D !== 32'h0) begin bad++; $display("FAIL midrst_rf got=%h exp=0", o_RD1_D); end
    $display("reset_midop: x5=%h", o_RD1_D);
  endtask

  initial begin
    rst = 1'b0; i_Stall_D = 1'b0; i_Flush_D = 1'b0;
    i_Instr_F = 32'h0; i_PC_F = 32'h0; i_PCPluse4_F = 32'h0;
    i_RegWrite_W = 1'b0; i_Rd_W = 5'd0; i_Result_W = 32'h0;
    test_reset();
    test_addi();
    test_bypass();
    test_stall_flush();
    test_branch_jump_mem();
    test_illegal();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
